// File: rtl/alu_seq_exec.sv
// ---------------------------------------------------------------------------
// alu_seq_exec -- execute-stage ALU driven by the 5-bit aluOp control word.
//
// aluOp layout: [4] use ALU, [3] funct7 bit, [2:0] funct3.
// One operation is accepted per in_valid/in_ready handshake.
// Add/sub, compare and logic ops finish in one cycle.
// Shifts normally go through an iterative shifter that moves one bit per
// cycle. The result is then offered on an out_valid/out_ready handshake.
//
// Build option:
//   ALU_FAST_SHIFT_EN  defined   -> shifts use a single-cycle barrel shifter.
//                                   The SHIFT state and counter are not built.
//                      undefined -> iterative 1-bit-per-cycle shifter.
//   Both builds give the same result for every operation.
//
// Ports:
//   clk        in   1     clock, rising edge
//   rst_n      in   1     asynchronous active-low reset
//   in_valid   in   1     operation presented
//   in_ready   out  1     unit idle, can accept (depends on state only)
//   aluOp      in   5     [use ALU][funct7 bit][funct3]
//   opA        in   XLEN  operand A (rs1)
//   opB        in   XLEN  operand B (rs2/imm); shift amount = opB[SHAMT_W-1:0]
//   out_valid  out  1     result available (depends on state only)
//   out_ready  in   1     downstream takes result
//   result     out  XLEN  registered result
//   zero       out  1     result == 0, derived from the result register
// ---------------------------------------------------------------------------
module alu_seq_exec #(
    parameter  int XLEN    = 32,
    localparam int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      aluOp,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

`ifdef ALU_FAST_SHIFT_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;
`endif

    state_t              r_state;
    state_t              w_next;
    logic [XLEN-1:0]     r_result;
    logic [XLEN-1:0]     w_alu;
    logic [2:0]          w_funct3;
    logic                w_f7;
    logic [SHAMT_W-1:0]  w_shamt;
    logic                w_accept;

    assign w_funct3 = aluOp[2:0];
    assign w_f7     = aluOp[3];
    assign w_shamt  = opB[SHAMT_W-1:0];
    assign w_accept = in_valid && (r_state == S_IDLE);

`ifdef ALU_FAST_SHIFT_EN
    // Kept in its own signed variable so the arithmetic shift is not turned
    // into a logical one by an unsigned expression context.
    logic signed [XLEN-1:0] w_sra;
    assign w_sra = $signed(opA) >>> w_shamt;
`else
    logic [SHAMT_W-1:0]  r_cnt;
    logic                r_right;   // shift direction of the op in flight
    logic                r_arith;   // right shift fills with the sign bit
    logic                w_is_shift;
    logic [XLEN-1:0]     w_step;

    assign w_is_shift = aluOp[4] && (w_funct3 == 3'b001 || w_funct3 == 3'b101);
    assign w_step = r_right ? {r_arith & r_result[XLEN-1], r_result[XLEN-1:1]}
                            : {r_result[XLEN-2:0], 1'b0};
`endif

    // Result for anything that completes at accept. In the iterative build a
    // shift loads opA here, which is the accumulator's start value and also
    // the answer for a shift by zero.
    always_comb begin
        w_alu = opB;
        if (aluOp[4]) begin
            unique case (w_funct3)
                3'b000: w_alu = w_f7 ? (opA - opB) : (opA + opB);
`ifdef ALU_FAST_SHIFT_EN
                3'b001: w_alu = opA << w_shamt;
                3'b101: w_alu = w_f7 ? w_sra : (opA >> w_shamt);
`else
                3'b001: w_alu = opA;
                3'b101: w_alu = opA;
`endif
                3'b010: w_alu = {{(XLEN-1){1'b0}}, ($signed(opA) < $signed(opB))};
                3'b011: w_alu = {{(XLEN-1){1'b0}}, (opA < opB)};
                3'b100: w_alu = opA ^ opB;
                3'b110: w_alu = opA | opB;
                3'b111: w_alu = opA & opB;
                default: w_alu = opB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid) begin
`ifdef ALU_FAST_SHIFT_EN
                    w_next = S_DONE;
`else
                    w_next = (w_is_shift && w_shamt != '0) ? S_SHIFT : S_DONE;
`endif
                end
            end
`ifndef ALU_FAST_SHIFT_EN
            // The edge that sees a count of 1 does the last shift.
            S_SHIFT: if (r_cnt == SHAMT_W'(1)) w_next = S_DONE;
`endif
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

`ifdef ALU_FAST_SHIFT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_result <= '0;
        else if (w_accept) r_result <= w_alu;
    end
`else
    // r_result doubles as the shift accumulator; out_valid is low while it moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_cnt    <= '0;
            r_right  <= 1'b0;
            r_arith  <= 1'b0;
        end else if (w_accept) begin
            r_result <= w_alu;
            r_cnt    <= w_shamt;
            r_right  <= w_funct3[2];
            r_arith  <= w_f7;
        end else if (r_state == S_SHIFT) begin
            r_result <= w_step;
            r_cnt    <= r_cnt - 1'b1;
        end
    end
`endif

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign zero      = (r_result == '0);

endmodule

// File: tb/tb_alu_seq_exec.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_exec -- directed vectors for alu_seq_exec.
// A behavioural model predicts the handshake and the result. A negedge
// process compares the DUT against it on every cycle. Each vector also
// carries a hand-computed result and latency.
// ---------------------------------------------------------------------------
module tb_alu_seq_exec;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  aluOp = '0;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;

    int total = 0;
    int bad   = 0;

    alu_seq_exec #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .aluOp(aluOp), .opA(opA), .opB(opB), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour written as plain arithmetic.
    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        sh = b[4:0];
        if (!op[4]) return b;
        case (op[2:0])
            3'd0: return op[3] ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin
                if (!op[3]) return a >> sh;
                return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // Extra cycles between accept and out_valid.
    function automatic int ref_lat(input logic [4:0] op, input logic [31:0] b);
`ifdef ALU_FAST_SHIFT_EN
        return 0;
`else
        if (op[4] && (op[2:0] == 3'd1 || op[2:0] == 3'd5)) return int'(b[4:0]);
        return 0;
`endif
    endfunction

    // Model of the handshake: busy while counting down, valid until taken.
    logic        m_valid = 1'b0;
    logic        m_busy  = 1'b0;
    int          m_wait  = 0;
    logic [31:0] m_res   = '0;
    logic [31:0] m_pend  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_busy = 1'b0; m_wait = 0; m_res = '0;
        end else if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
        end else if (m_busy) begin
            m_wait--;
            if (m_wait == 0) begin m_busy = 1'b0; m_valid = 1'b1; m_res = m_pend; end
        end else if (in_valid) begin
            m_pend = ref_alu(aluOp, opA, opB);
            m_wait = ref_lat(aluOp, opB);
            if (m_wait == 0) begin m_valid = 1'b1; m_res = m_pend; end
            else m_busy = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cmp_in_ready", 32'(in_ready), 32'(!(m_valid || m_busy)));
            chk("cmp_out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("cmp_result", result, m_res);
                chk("cmp_zero", 32'(zero), 32'(m_res == 32'h0));
            end
        end
    end

    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input int hold);
        int n;
        int exp_lat;
`ifdef ALU_FAST_SHIFT_EN
        exp_lat = 0;
`else
        exp_lat = lat;
`endif
        chk("pre_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; aluOp = op; opA = a; opB = b; out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(exp_lat));
        chk("vec_result", result, exp);
        chk("vec_zero", 32'(zero), 32'(exp == 32'h0));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; aluOp = 5'b10000; opA = 32'd1; opB = 32'd1;
            chk("hold_result", result, exp);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_out_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_result", result, 32'h0);
        chk("rst_zero", 32'(zero), 32'd1);
        rst_n = 1'b1;

        // Pin the model with hand-computed values.
        chk("model_sra", ref_alu(5'b11101, 32'h8000_0000, 32'd4), 32'hF800_0000);
        chk("model_slt", ref_alu(5'b10010, 32'hFFFF_FFFF, 32'd1), 32'd1);
        chk("model_sub", ref_alu(5'b11000, 32'd0, 32'd1), 32'hFFFF_FFFF);

        @(posedge clk); #1;
        do_op(5'b10000, 32'd5, 32'd7, 32'd12, 0, 0);
        do_op(5'b11000, 32'd5, 32'd5, 32'd0, 0, 0);
        do_op(5'b11000, 32'd0, 32'd1, 32'hFFFF_FFFF, 0, 0);
        do_op(5'b11101, 32'h8000_0000, 32'd4, 32'hF800_0000, 4, 0);
        do_op(5'b10101, 32'h8000_0000, 32'd4, 32'h0800_0000, 4, 0);
        do_op(5'b10001, 32'd1, 32'h25, 32'h20, 5, 0);
        do_op(5'b10001, 32'h0000_ABCD, 32'h20, 32'h0000_ABCD, 0, 0);
        do_op(5'b11101, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 31, 0);
        do_op(5'b10001, 32'd3, 32'd31, 32'h8000_0000, 31, 0);
        do_op(5'b10010, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0);
        do_op(5'b10011, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0);
        do_op(5'b00000, 32'd0, 32'h1234, 32'h1234, 0, 0);
        do_op(5'b01111, 32'd5, 32'h99, 32'h99, 0, 0);
        do_op(5'b10100, 32'hF0F0, 32'hFF00, 32'h0FF0, 0, 0);
        do_op(5'b11100, 32'hF0F0, 32'hFF00, 32'h0FF0, 0, 0);
        do_op(5'b10110, 32'hF0F0, 32'hFF00, 32'hFFF0, 0, 0);
        do_op(5'b10111, 32'hF0F0, 32'hFF00, 32'hF000, 0, 0);
        do_op(5'b10000, 32'd3, 32'd4, 32'd7, 0, 10);

        // Reset in the middle of a long shift.
        in_valid = 1'b1; aluOp = 5'b10001; opA = 32'd1; opB = 32'd20; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_result", result, 32'h0);
        chk("midrst_zero", 32'(zero), 32'd1);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        do_op(5'b10000, 32'd100, 32'd23, 32'd123, 0, 0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_seq_exec.md
# alu_seq_exec

- Execute-stage ALU on the consumer side of the 5-bit `aluOp` control word produced by the ALU-control decoder.
- `aluOp` layout is [use-ALU][funct7 bit][funct3].
- Takes one operation per handshake and computes it.
- Add/sub and logic ops take one cycle; shifts run through an iterative 1-bit-per-cycle shifter.
- Returns result and a zero flag (used for branch compare) over a valid/ready output handshake.

## Interface
- `XLEN`, 32, datapath width; `SHAMT_W = $clog2(XLEN)` is derived and not overridable.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  unit can accept an operation.
- `aluOp`  in  5  [4]=use ALU, [3]=funct7 bit, [2:0]=funct3.
- `opA`  in  XLEN  operand A (rs1).
- `opB`  in  XLEN  operand B (rs2 or immediate); the shift amount is `opB[SHAMT_W-1:0]`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream takes result.
- `result`  out  XLEN  registered result.
- `zero`  out  1  `result == 0`, derived from the result register.

## Operation
- States: IDLE, SHIFT, DONE.
- `in_ready = (state == IDLE)`.
- Accept when `in_valid && in_ready`; operands and op are captured on that edge.
- `aluOp[4]=0`: result = opB (load/store/jump pass-through). `aluOp[3:0]` ignored.
- `aluOp[4]=1`, decoded on {aluOp[3], aluOp[2:0]}:
  - x000: add when [3]=0, sub when [3]=1.
  - x001: sll.
  - x010: slt (signed).
  - x011: sltu.
  - x100: xor.
  - x101: srl when [3]=0, sra when [3]=1.
  - x110: or.
  - x111: and.
  - [3] is ignored for every funct3 except 000 and 101.
- Arithmetic is modulo 2^XLEN with no overflow flag.
- slt/sltu produce 1 or 0, zero-extended to XLEN.
- sra fills with the sign bit of opA; srl and sll fill with 0.
- Non-shift ops: result computed combinationally at accept and registered; IDLE→DONE.
- Shift ops: accumulator = opA and counter = shamt are loaded at accept.
  - shamt=0: IDLE→DONE with result = opA.
  - Otherwise IDLE→SHIFT. Each SHIFT edge shifts the accumulator 1 bit and decrements the counter.
  - When the counter is 1 on an edge, that edge performs the final shift and goes to DONE.
- DONE: `out_valid=1`; `result` and `zero` are held stable until `out_ready`. DONE→IDLE on `out_ready`.
- `in_valid` is ignored in SHIFT and DONE; the upstream stage must hold its request.
- Reset (any state, including mid-shift): state=IDLE, `result=0`, `zero=1`, `out_valid=0`, `in_ready=1`. Any in-flight operation is discarded.

## Timing
- Non-shift op: accepted at edge k; `out_valid` is high from after edge k+1.
- Shift by n>0: accepted at edge k; `out_valid` is high from after edge k+n+1.
- Shift by 0: same timing as a non-shift op.
- Result leaves at the first edge where `out_valid && out_ready`.
- `in_ready` rises the following cycle.
- No combinational path from `in_valid`/`aluOp` to any output.
- `in_ready` and `out_valid` depend on state only.
- Peak throughput is one op per 2 cycles with `out_ready` held high.

## Configuration
- `ALU_FAST_SHIFT_EN` defined: shifts use a single-cycle barrel shifter.
  - SHIFT state and counter are not built.
  - Every op has non-shift timing.
- Undefined (default): iterative shifter as described above.
- Results are bit-identical in both builds.

## Test plan
- Reset mid-shift: start sll with opA=1, opB=20; assert `rst_n=0` at cycle 5.
  - Expect `out_valid=0`, `result=0`, `zero=1`, `in_ready=1`.
  - After release, the next add completes normally.
- Add/sub:
  - aluOp=10000, opA=5, opB=7 → result=12, `out_valid` at k+1.
  - aluOp=11000, opA=5, opB=5 → result=0, zero=1.
  - aluOp=11000, opA=0, opB=1 → result=0xFFFFFFFF.
- Shifts:
  - aluOp=11101 (sra), opA=0x80000000, opB=4 → 0xF8000000, `out_valid` at k+5.
  - aluOp=10101 (srl), same operands → 0x08000000.
  - aluOp=10001, opB=0x25 (shamt 5), opA=1 → 0x20.
- Compares:
  - aluOp=10010 (slt), opA=0xFFFFFFFF, opB=1 → 1.
  - aluOp=10011 (sltu), same operands → 0.
- Pass-through and logic:
  - aluOp=00000, opB=0x1234 → 0x1234.
  - xor/or/and with opA=0xF0F0, opB=0xFF00 → 0x0FF0, 0xFFF0, 0xF000.
- Backpressure:
  - Hold `out_ready=0` for 10 cycles after DONE → result/zero stable, `in_ready=0`, a new `in_valid` is ignored.
  - Release → transfer once, `in_ready=1` next cycle.
  - Repeat the shift cases with `ALU_FAST_SHIFT_EN` defined → same values, latency k+1.
